cipher_load_ctrl: RTL and testbench
===================================

Name: cipher_load_ctrl

Overview:
- Sequencer for one cipher transaction in the XOR cipher datapath, using the shared serial input.
- It drives the iLoading flags of two DATA_SIZE-bit serial deserializers (key, then text) and pulses a latch strobe so the datapath captures key XOR text.
- It then steps a bit index that selects the result bit, MSB first, onto the serial output.
- It also reports busy/done status to the top level.

Parameters:
DATA_SIZE, 4, bits per key/text/result word; legal values >= 2
CW, $clog2(DATA_SIZE) (localparam), width of the phase counter and bit index

Ports:
iClk  input  1  system clock (the half clock also fed to the deserializers)
iRst  input  1  reset; asynchronous, active-low
iEn  input  1  global enable, shared with the deserializers; low freezes all state
iStart  input  1  transaction request; sampled only in IDLE
iAbort  input  1  synchronous abort request
oKey_loading  output  1  drives the key deserializer iLoading
oText_loading  output  1  drives the text deserializer iLoading
oXor_latch  output  1  strobe: capture key^text into the result register
oTx_shift  output  1  high while result bits are presented on serial out
oTx_bit_sel  output  CW  index of the result bit on serial out
oBusy  output  1  high in any state other than IDLE
oDone  output  1  one-cycle completion strobe
oState  output  3  state encoding, for debug

Behaviour:
- Clocking and reset
  - Single clock domain; all registers update on posedge iClk.
  - iRst low forces the following immediately, regardless of the clock: state = IDLE, phase counter = 0.
  - While reset is held, every output is 0 and oState = 0.
  - Reset mid-transaction aborts with no oDone.
- State encoding: IDLE=0, LOAD_KEY=1, LOAD_TEXT=2, LATCH=3, SHIFT_OUT=4, DONE=5. Codes 6 and 7 go to IDLE on the next enabled edge.
- iEn low: state and counter hold. Decoded level outputs keep their values. oXor_latch and oDone are forced to 0.
- Transitions (each evaluated only when iEn=1):
  - IDLE -> LOAD_KEY when iStart=1; the counter clears.
  - LOAD_KEY: the counter increments each cycle. At count=DATA_SIZE-1 go to LOAD_TEXT and clear the counter. Total of exactly DATA_SIZE cycles.
  - LOAD_TEXT: same rule as LOAD_KEY, then go to LATCH.
  - LATCH: one cycle, then SHIFT_OUT with the counter cleared.
  - SHIFT_OUT: DATA_SIZE cycles, then DONE.
  - DONE: one cycle, then IDLE, unconditionally.
- Abort and start
  - iAbort=1 in any state other than IDLE: next state is IDLE, the counter clears, and oDone does not fire.
  - iAbort has priority over iStart and over any normal transition.
  - iAbort=1 together with iStart=1 in IDLE: stay in IDLE.
  - iStart outside IDLE is ignored.
  - iStart held high through DONE does not start a transaction back-to-back. IDLE lasts at least one cycle, and the new start is taken on the following edge.
- Outputs (Moore decode of the registered state)
  - oKey_loading = (state==LOAD_KEY)
  - oText_loading = (state==LOAD_TEXT)
  - oXor_latch = (state==LATCH) & iEn
  - oTx_shift = (state==SHIFT_OUT)
  - oDone = (state==DONE) & iEn
  - oBusy = (state!=IDLE)
  - oTx_bit_sel = DATA_SIZE-1-count in SHIFT_OUT, otherwise 0
- Timing: with iStart sampled at edge 0 and iEn held high:
  - LOAD_KEY occupies cycles 1..N.
  - LOAD_TEXT occupies cycles N+1..2N.
  - LATCH is cycle 2N+1.
  - SHIFT_OUT occupies cycles 2N+2..3N+1.
  - DONE is cycle 3N+2.
  - For N=4, oDone is high in cycle 14.
- Counter width: the counter never exceeds DATA_SIZE-1 and has no wrap-around beyond a phase. For non-power-of-two DATA_SIZE, the terminal compare is exact.

Test Plan:
- Nominal, DATA_SIZE=4, iEn=1, iStart pulse at cycle 0:
  - oKey_loading is high for cycles 1-4 and oText_loading for cycles 5-8.
  - oXor_latch is high in cycle 9 only.
  - oTx_shift is high for cycles 10-13, with oTx_bit_sel = 3,2,1,0.
  - oDone is high in cycle 14 only; oBusy is high for cycles 1-14.
- iEn gap: deassert iEn for 3 cycles during LOAD_TEXT and again in LATCH.
  - Total duration stretches by exactly the gap cycles.
  - oXor_latch is 0 while iEn=0 and is high for exactly one enabled cycle.
  - The load windows still each contain exactly 4 enabled cycles.
- Abort: assert iAbort in SHIFT_OUT at oTx_bit_sel=2 -> next cycle IDLE, oBusy=0, oDone never asserts. A following iStart runs a full, correct transaction.
- Start held high continuously: consecutive transactions are separated by exactly one IDLE cycle (oDone at 14, next oKey_loading at cycle 16).
- Async reset: drop iRst mid-LOAD_KEY between clock edges -> all outputs go to 0 without waiting for a clock. After release, no activity occurs until iStart.
- Parameter sweep, DATA_SIZE=5 and DATA_SIZE=2:
  - Each phase lasts exactly N cycles.
  - oTx_bit_sel counts N-1..0 and oDone falls in cycle 3N+2.
  - iStart together with iAbort in IDLE leaves oBusy=0.

Source files
------------

// File: rtl/cipher_load_ctrl.sv
// Sequencer for one XOR-cipher transaction: load key, load text, latch key^text,
// then present the result MSB first on the shared serial output.
module cipher_load_ctrl #(
    parameter  int DATA_SIZE = 4,
    localparam int CW        = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iEn,
    input  logic          iStart,
    input  logic          iAbort,
    output logic          oKey_loading,
    output logic          oText_loading,
    output logic          oXor_latch,
    output logic          oTx_shift,
    output logic [CW-1:0] oTx_bit_sel,
    output logic          oBusy,
    output logic          oDone,
    output logic [2:0]    oState
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_KEY  = 3'd1,
        LOAD_TEXT = 3'd2,
        LATCH     = 3'd3,
        SHIFT_OUT = 3'd4,
        DONE      = 3'd5
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(DATA_SIZE - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Abort outranks every other transition; nothing moves while iEn is low.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        if (iEn) begin
            if (iAbort && (state != IDLE)) begin
                state_nxt = IDLE;
                count_nxt = '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (iStart && !iAbort) begin
                            state_nxt = LOAD_KEY;
                            count_nxt = '0;
                        end
                    end
                    LOAD_KEY: begin
                        if (count == LAST) begin
                            state_nxt = LOAD_TEXT;
                            count_nxt = '0;
                        end else begin
                            count_nxt = count + CW'(1);
                        end
                    end
                    LOAD_TEXT: begin
                        if (count == LAST) begin
                            state_nxt = LATCH;
                            count_nxt = '0;
                        end else begin
                            count_nxt = count + CW'(1);
                        end
                    end
                    LATCH: begin
                        state_nxt = SHIFT_OUT;
                        count_nxt = '0;
                    end
                    SHIFT_OUT: begin
                        if (count == LAST) begin
                            state_nxt = DONE;
                            count_nxt = '0;
                        end else begin
                            count_nxt = count + CW'(1);
                        end
                    end
                    DONE: begin
                        state_nxt = IDLE;
                        count_nxt = '0;
                    end
                    default: begin
                        state_nxt = IDLE;
                        count_nxt = '0;
                    end
                endcase
            end
        end
    end

    assign oKey_loading  = (state == LOAD_KEY);
    assign oText_loading = (state == LOAD_TEXT);
    assign oXor_latch    = (state == LATCH) && iEn;
    assign oTx_shift     = (state == SHIFT_OUT);
    assign oTx_bit_sel   = (state == SHIFT_OUT) ? (LAST - count) : '0;
    assign oBusy         = (state != IDLE);
    assign oDone         = (state == DONE) && iEn;
    assign oState        = state;

endmodule

// File: tb/tb_cipher_load_ctrl.sv
// Directed, table-driven bench for cipher_load_ctrl (DATA_SIZE 4, with 5 and 2
// instances for the parameter sweep).
module tb_cipher_load_ctrl;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic en    = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;

    always #5 clk = ~clk;

    logic       key4, text4, latch4, shift4, busy4, done4;
    logic [1:0] sel4;
    logic [2:0] st4;
    logic       key5, text5, latch5, shift5, busy5, done5;
    logic [2:0] sel5;
    logic [2:0] st5;
    logic       key2, text2, latch2, shift2, busy2, done2;
    logic [0:0] sel2;
    logic [2:0] st2;

    cipher_load_ctrl #(.DATA_SIZE(4)) dut4 (
        .iClk(clk), .iRst(rst), .iEn(en), .iStart(start), .iAbort(abort),
        .oKey_loading(key4), .oText_loading(text4), .oXor_latch(latch4),
        .oTx_shift(shift4), .oTx_bit_sel(sel4), .oBusy(busy4), .oDone(done4),
        .oState(st4)
    );

    cipher_load_ctrl #(.DATA_SIZE(5)) dut5 (
        .iClk(clk), .iRst(rst), .iEn(en), .iStart(start), .iAbort(abort),
        .oKey_loading(key5), .oText_loading(text5), .oXor_latch(latch5),
        .oTx_shift(shift5), .oTx_bit_sel(sel5), .oBusy(busy5), .oDone(done5),
        .oState(st5)
    );

    cipher_load_ctrl #(.DATA_SIZE(2)) dut2 (
        .iClk(clk), .iRst(rst), .iEn(en), .iStart(start), .iAbort(abort),
        .oKey_loading(key2), .oText_loading(text2), .oXor_latch(latch2),
        .oTx_shift(shift2), .oTx_bit_sel(sel2), .oBusy(busy2), .oDone(done2),
        .oState(st2)
    );

    // Flag order: {key, text, latch, shift, busy, done}
    localparam logic [5:0] F_IDLE      = 6'b000000;
    localparam logic [5:0] F_KEY       = 6'b100010;
    localparam logic [5:0] F_TEXT      = 6'b010010;
    localparam logic [5:0] F_LATCH     = 6'b001010;
    localparam logic [5:0] F_LATCH_OFF = 6'b000010;
    localparam logic [5:0] F_SHIFT     = 6'b000110;
    localparam logic [5:0] F_DONE      = 6'b000011;

    typedef struct {
        logic       s;
        logic       a;
        logic       e;
        logic [5:0] flags;
        int         sel;
        int         st;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    function automatic void push(input logic s, input logic a, input logic e,
                                 input logic [5:0] f, input int sel, input int st);
        vec_t v;
        v.s = s; v.a = a; v.e = e; v.flags = f; v.sel = sel; v.st = st;
        vecs.push_back(v);
    endfunction

    // Cycles 1..14 of a nominal N=4 transaction; hold keeps iStart asserted.
    function automatic void pushBody(input logic hold);
        for (int i = 0; i < 4; i++) push(hold, 1'b0, 1'b1, F_KEY, 0, 1);
        for (int i = 0; i < 4; i++) push(hold, 1'b0, 1'b1, F_TEXT, 0, 2);
        push(hold, 1'b0, 1'b1, F_LATCH, 0, 3);
        for (int i = 0; i < 4; i++) push(hold, 1'b0, 1'b1, F_SHIFT, 3 - i, 4);
        push(hold, 1'b0, 1'b1, F_DONE, 0, 5);
    endfunction

    function automatic void pushTxn(input logic hold);
        push(1'b1, 1'b0, 1'b1, F_IDLE, 0, 0);
        pushBody(hold);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic e);
        @(negedge clk);
        start = s;
        abort = a;
        en    = e;
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " d4 flags"}, 32'({key4, text4, latch4, shift4, busy4, done4}), 32'(F_IDLE));
        checkOutput({tag, " d4 sel"}, 32'(sel4), 32'd0);
        checkOutput({tag, " d4 state"}, 32'(st4), 32'd0);
        checkOutput({tag, " d5 flags"}, 32'({key5, text5, latch5, shift5, busy5, done5}), 32'(F_IDLE));
        checkOutput({tag, " d2 flags"}, 32'({key2, text2, latch2, shift2, busy2, done2}), 32'(F_IDLE));
    endtask

    // Timing for DATA_SIZE=n is stated directly from the cycle numbering.
    task automatic runSweep(input int n);
        logic [31:0] a_st, a_sel, a_done, a_busy;
        int exp_st, exp_sel;
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        a_busy = (n == 5) ? 32'(busy5) : 32'(busy2);
        a_st   = (n == 5) ? 32'(st5) : 32'(st2);
        checkOutput($sformatf("N%0d start+abort busy", n), a_busy, 32'd0);
        checkOutput($sformatf("N%0d start+abort state", n), a_st, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int c = 1; c <= 3 * n + 3; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            exp_sel = 0;
            if (c <= n)                exp_st = 1;
            else if (c <= 2 * n)       exp_st = 2;
            else if (c == 2 * n + 1)   exp_st = 3;
            else if (c <= 3 * n + 1) begin
                exp_st  = 4;
                exp_sel = 3 * n + 1 - c;
            end
            else if (c == 3 * n + 2)   exp_st = 5;
            else                       exp_st = 0;
            if (n == 5) begin
                a_st = 32'(st5); a_sel = 32'(sel5); a_done = 32'(done5); a_busy = 32'(busy5);
            end else begin
                a_st = 32'(st2); a_sel = 32'(sel2); a_done = 32'(done2); a_busy = 32'(busy2);
            end
            checkOutput($sformatf("N%0d c%0d state", n, c), a_st, 32'(exp_st));
            checkOutput($sformatf("N%0d c%0d sel", n, c), a_sel, 32'(exp_sel));
            checkOutput($sformatf("N%0d c%0d done", n, c), a_done, 32'(exp_st == 5));
            checkOutput($sformatf("N%0d c%0d busy", n, c), a_busy, 32'(exp_st != 0));
        end
    endtask

    initial begin
        // Nominal transaction followed by two idle cycles.
        pushTxn(1'b0);
        push(1'b0, 1'b0, 1'b1, F_IDLE, 0, 0);
        push(1'b0, 1'b0, 1'b1, F_IDLE, 0, 0);

        // iEn gaps: three cycles inside LOAD_TEXT, three in LATCH.
        push(1'b1, 1'b0, 1'b1, F_IDLE, 0, 0);
        for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 1'b1, F_KEY, 0, 1);
        push(1'b0, 1'b0, 1'b1, F_TEXT, 0, 2);
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, F_TEXT, 0, 2);
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b1, F_TEXT, 0, 2);
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 1'b0, F_LATCH_OFF, 0, 3);
        push(1'b0, 1'b0, 1'b1, F_LATCH, 0, 3);
        for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 1'b1, F_SHIFT, 3 - i, 4);
        push(1'b0, 1'b0, 1'b1, F_DONE, 0, 5);
        push(1'b0, 1'b0, 1'b1, F_IDLE, 0, 0);

        // Abort while bit 2 is on the serial output, then a clean transaction.
        push(1'b1, 1'b0, 1'b1, F_IDLE, 0, 0);
        for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 1'b1, F_KEY, 0, 1);
        for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 1'b1, F_TEXT, 0, 2);
        push(1'b0, 1'b0, 1'b1, F_LATCH, 0, 3);
        push(1'b0, 1'b0, 1'b1, F_SHIFT, 3, 4);
        push(1'b0, 1'b1, 1'b1, F_SHIFT, 2, 4);
        push(1'b0, 1'b0, 1'b1, F_IDLE, 0, 0);
        push(1'b0, 1'b0, 1'b1, F_IDLE, 0, 0);
        pushTxn(1'b0);
        push(1'b0, 1'b0, 1'b1, F_IDLE, 0, 0);

        // Start held: done at 14, single idle at 15, key loading again at 16.
        pushTxn(1'b1);
        push(1'b1, 1'b0, 1'b1, F_IDLE, 0, 0);
        pushBody(1'b0);
        push(1'b0, 1'b0, 1'b1, F_IDLE, 0, 0);

        #2;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].s, vecs[i].a, vecs[i].e);
            checkOutput($sformatf("vec%0d flags", i),
                        32'({key4, text4, latch4, shift4, busy4, done4}), 32'(vecs[i].flags));
            checkOutput($sformatf("vec%0d sel", i), 32'(sel4), 32'(vecs[i].sel));
            checkOutput($sformatf("vec%0d state", i), 32'(st4), 32'(vecs[i].st));
        end

        // Asynchronous reset between edges in the middle of LOAD_KEY.
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("pre-reset key", 32'(key4), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        checkAllZero("async reset");
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkAllZero("reset held");
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkAllZero($sformatf("post-reset idle%0d", i));
        end

        runSweep(5);
        runSweep(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
